logic_gate_pipe: RTL and testbench
==================================

Name: logic_gate_pipe

Overview:
Parametrised, registered multi-input bitwise logic unit. It is the successor to the single 2-input gate cell.
- Applies one of eight selectable gate operations bitwise across NUM_IN operands of WIDTH bits each.
- Uses a valid/ready handshake on both sides.
- Buffers results in a 2-entry output queue so upstream is not stalled by one cycle of backpressure.
- Counts completed results.
- Sits between a stimulus/operand source and any downstream consumer in the gate-level datapath.

Parameters:
- WIDTH, 8, bit width of each operand and of the result.
- NUM_IN, 2, number of operands; legal range 2..8.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set and op are valid this cycle.
- in_ready  output  1  block can accept an operand set this cycle.
- in_data  input  NUM_IN*WIDTH  operands; operand k occupies bits [k*WIDTH +: WIDTH].
- op  input  3  operation select, sampled with in_data.
- out_valid  output  1  head result is valid.
- out_ready  input  1  downstream accepts the head result.
- out_data  output  WIDTH  head result.
- out_op  output  3  op code that produced the head result.
- op_count  output  CNT_W  number of completed output transfers, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state (rst_n low, effective immediately):
  - queue empty; out_valid=0, out_data=0, out_op=0, op_count=0;
  - in_ready forced to 0 while rst_n is low.
  - Reset mid-operation discards all queued results; no partial transfer completes.
- Operations, each bitwise across operands 0..NUM_IN-1:
  - 000 AND
  - 001 OR
  - 010 XOR (odd parity per bit)
  - 011 NAND
  - 100 NOR
  - 101 XNOR (inverse of 010)
  - 110 BUF: operand 0 passed unchanged
  - 111 NOT: ~operand 0
- Accept: transfer when in_valid && in_ready on a rising edge. The result is computed combinationally from in_data/op and written with its op code into the queue tail on that same edge.
- Latency: result visible on out_data with out_valid=1 in the cycle after acceptance (1 cycle) when the queue was empty.
- in_ready = rst_n && (queue count < 2). It is registered-state derived only and never depends on out_ready.
- Output transfer: when out_valid && out_ready on a rising edge, the head is popped.
- Head outputs:
  - out_valid = (count != 0).
  - out_data and out_op show the head entry when out_valid=1, and are driven 0 when out_valid=0.
- Ordering: strict FIFO; results leave in acceptance order.
- Count rules:
  - push only: count+1;
  - pop only: count-1;
  - push and pop in the same cycle: allowed only with count=1 (count stays 1, new entry becomes the head next cycle);
  - count=2: in_ready=0, so no push occurs; a pop that cycle makes in_ready=1 the next cycle.
- Stability: while out_valid=1 and out_ready=0, out_data and out_op hold stable.
- Counter: op_count increments by 1 on each output transfer and saturates at 2^CNT_W-1 (no wrap).
- X handling: in_data and op are ignored when in_valid=0.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 entries queued -> out_valid=0, out_data=0, op_count=0 and in_ready=0 immediately; after release in_ready=1 on the first cycle.
- Truth table (WIDTH=8, NUM_IN=3, operands A5,3C,0F, out_ready=1):
  - op 000 -> 04
  - op 001 -> BF
  - op 010 -> 96
  - op 011 -> FB
  - op 100 -> 40
  - op 101 -> 69
  - op 110 -> 0F
  - op 111 -> F0
  - Each result appears exactly 1 cycle after acceptance; op_count ends at 8.
- Backpressure: out_ready=0, push results 04 and BF -> in_ready=0 after the second push; third operand set held pending; out_data stays 04. Raise out_ready -> 04, BF, then the third result delivered in order, none lost or duplicated.
- Simultaneous push/pop: count=1, in_valid=1 and out_ready=1 every cycle for 10 cycles -> one result per cycle, count stays 1, out_valid continuously 1.
- Counter saturation: CNT_W=3, 10 transfers -> op_count reads 7 after the 7th transfer and stays 7.
- Parameter sweep: NUM_IN=2 and 8, WIDTH=1 and 16, random ops and operands with random in_valid/out_ready -> every output matches the reference model; no handshake violation.

Source files
------------

// File: rtl/logic_gate_pipe.sv
// Registered multi-operand bitwise logic unit with valid/ready handshakes,
// a two-entry result queue and a saturating count of delivered results.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [2:0]              out_op,
    output logic [CNT_W-1:0]        op_count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_BUF  = 3'b110,
        OP_NOT  = 3'b111
    } gate_op_e;

    logic [WIDTH-1:0] data_q [2];
    logic [2:0]       op_q   [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;

    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;
    logic [WIDTH-1:0] operand0;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    // Reduce all operands once; every gate is a selection or inversion of these.
    always_comb begin
        and_v    = '1;
        or_v     = '0;
        xor_v    = '0;
        operand0 = in_data[WIDTH-1:0];
        for (int k = 0; k < NUM_IN; k++) begin
            and_v = and_v & in_data[k*WIDTH +: WIDTH];
            or_v  = or_v  | in_data[k*WIDTH +: WIDTH];
            xor_v = xor_v ^ in_data[k*WIDTH +: WIDTH];
        end
        case (gate_op_e'(op))
            OP_AND:  result = and_v;
            OP_OR:   result = or_v;
            OP_XOR:  result = xor_v;
            OP_NAND: result = ~and_v;
            OP_NOR:  result = ~or_v;
            OP_XNOR: result = ~xor_v;
            OP_BUF:  result = operand0;
            OP_NOT:  result = ~operand0;
            default: result = '0;
        endcase
    end

    assign in_ready  = rst_n && (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? data_q[rd_ptr] : '0;
    assign out_op    = out_valid ? op_q[rd_ptr]   : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            op_q[0]   <= 3'b000;
            op_q[1]   <= 3'b000;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            op_count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= result;
                op_q[wr_ptr]   <= op;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (pop && (op_count != {CNT_W{1'b1}})) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: directed truth table, backpressure,
// reset and saturation on an 8x3 unit, plus random sweeps on 1x2 and 16x8 units.
module tb_logic_gate_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [23:0] a_in_data;
    logic [2:0]  a_op, a_out_op;
    logic [7:0]  a_out_data;
    logic [15:0] a_op_count;

    logic        b_in_ready, b_out_valid;
    logic [2:0]  b_out_op;
    logic [7:0]  b_out_data;
    logic [2:0]  b_op_count;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [1:0]  c_in_data;
    logic [2:0]  c_op, c_out_op;
    logic [0:0]  c_out_data;
    logic [15:0] c_op_count;

    logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [127:0] d_in_data;
    logic [2:0]   d_op, d_out_op;
    logic [15:0]  d_out_data;
    logic [15:0]  d_op_count;

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .op(a_op), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_op(a_out_op), .op_count(a_op_count));

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(b_in_ready),
        .in_data(a_in_data), .op(a_op), .out_valid(b_out_valid), .out_ready(a_out_ready),
        .out_data(b_out_data), .out_op(b_out_op), .op_count(b_op_count));

    logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .op(c_op), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_op(c_out_op), .op_count(c_op_count));

    logic_gate_pipe #(.WIDTH(16), .NUM_IN(8), .CNT_W(16)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .op(d_op), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_op(d_out_op), .op_count(d_op_count));

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qc[$];
    exp_t qd[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   xfer_a     = 0;
    int   xfer_c     = 0;
    int   xfer_d     = 0;

    // Per bit, count how many operands are 1 and decide each gate from that count.
    function automatic logic [15:0] ref_model(input logic [127:0] data, input int n,
                                               input int w, input logic [2:0] opc);
        logic [15:0] r;
        int ones;
        r = '0;
        for (int b = 0; b < w; b++) begin
            ones = 0;
            for (int k = 0; k < n; k++) ones += int'(data[k*w+b]);
            case (opc)
                3'd0: r[b] = (ones == n);
                3'd1: r[b] = (ones != 0);
                3'd2: r[b] = (ones % 2 == 1);
                3'd3: r[b] = (ones != n);
                3'd4: r[b] = (ones == 0);
                3'd5: r[b] = (ones % 2 == 0);
                3'd6: r[b] = data[b];
                default: r[b] = ~data[b];
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Offers one operand set to dut_a and holds it until accepted (bounded).
    task automatic applyStimulus(input logic [23:0] data, input logic [2:0] opc, output int waited);
        a_in_data  = data;
        a_op       = opc;
        a_in_valid = 1'b1;
        waited     = 0;
        while (!a_in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (a_in_ready) begin
            qa.push_back(exp_t'{op: opc, data: ref_model({104'b0, data}, 3, 8, opc)});
            @(posedge clk); #1;
        end else begin
            reportFail("a_accept_timeout");
        end
        a_in_valid = 1'b0;
    endtask

    initial begin : mon_a
        logic       held;
        logic [7:0] hd;
        logic [2:0] ho;
        exp_t       e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else if (a_out_valid) begin
                if (held) begin
                    checkOutput("a_hold_data", 32'(a_out_data), 32'(hd));
                    checkOutput("a_hold_op", 32'(a_out_op), 32'(ho));
                end
                if (a_out_ready) begin
                    if (qa.size() == 0) begin
                        reportFail("a_spurious_output");
                    end else begin
                        e = qa.pop_front();
                        checkOutput("a_data", 32'(a_out_data), 32'(e.data));
                        checkOutput("a_op", 32'(a_out_op), 32'(e.op));
                        checkOutput("b_valid", 32'(b_out_valid), 32'd1);
                        checkOutput("b_data", 32'(b_out_data), 32'(e.data));
                        checkOutput("b_op", 32'(b_out_op), 32'(e.op));
                    end
                    checkOutput("a_op_count", 32'(a_op_count), 32'(xfer_a));
                    checkOutput("b_op_count_sat", 32'(b_op_count), 32'(xfer_a > 7 ? 7 : xfer_a));
                    xfer_a++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = a_out_data;
                    ho   = a_out_op;
                end
            end else begin
                held = 1'b0;
                checkOutput("a_idle_data", 32'(a_out_data), 32'd0);
                checkOutput("a_idle_op", 32'(a_out_op), 32'd0);
            end
        end
    end

    initial begin : mon_c
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && c_out_valid && c_out_ready) begin
                if (qc.size() == 0) begin
                    reportFail("c_spurious_output");
                end else begin
                    e = qc.pop_front();
                    checkOutput("c_data", 32'(c_out_data), 32'(e.data));
                    checkOutput("c_op", 32'(c_out_op), 32'(e.op));
                end
                checkOutput("c_op_count", 32'(c_op_count), 32'(xfer_c));
                xfer_c++;
            end
        end
    end

    initial begin : mon_d
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && d_out_valid && d_out_ready) begin
                if (qd.size() == 0) begin
                    reportFail("d_spurious_output");
                end else begin
                    e = qd.pop_front();
                    checkOutput("d_data", 32'(d_out_data), 32'(e.data));
                    checkOutput("d_op", 32'(d_out_op), 32'(e.op));
                end
                checkOutput("d_op_count", 32'(d_op_count), 32'(xfer_d));
                xfer_d++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0] truth [8];
        int waited;
        int waited3;
        int spins;

        truth[0] = 8'h04; truth[1] = 8'hBF; truth[2] = 8'h96; truth[3] = 8'hFB;
        truth[4] = 8'h40; truth[5] = 8'h69; truth[6] = 8'h0F; truth[7] = 8'hF0;

        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_op = '0; a_out_ready = 1'b1;
        c_in_valid = 0; c_in_data = '0; c_op = '0; c_out_ready = 1'b1;
        d_in_valid = 0; d_in_data = '0; d_op = '0; d_out_ready = 1'b1;

        #1;
        checkOutput("reset_in_ready", 32'(a_in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("reset_op_count", 32'(a_op_count), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_in_ready", 32'(a_in_ready), 32'd1);

        $display("[TB] truth table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(24'hA53C0F, 3'(i), waited);
            checkOutput("tt_latency_valid", 32'(a_out_valid), 32'd1);
            checkOutput("tt_result", 32'(a_out_data), 32'(truth[i]));
            checkOutput("tt_out_op", 32'(a_out_op), 32'(i));
        end
        @(posedge clk); #1;
        checkOutput("tt_op_count", 32'(a_op_count), 32'd8);
        checkOutput("tt_sat_count", 32'(b_op_count), 32'd7);

        $display("[TB] backpressure");
        a_out_ready = 1'b0;
        applyStimulus(24'hA53C0F, 3'd0, waited);
        applyStimulus(24'hA53C0F, 3'd1, waited);
        checkOutput("bp_in_ready_full", 32'(a_in_ready), 32'd0);
        checkOutput("bp_b_in_ready_full", 32'(b_in_ready), 32'd0);
        fork
            applyStimulus(24'hA53C0F, 3'd2, waited3);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #2;
                    checkOutput("bp_head_stable", 32'(a_out_data), 32'h04);
                    checkOutput("bp_stalled", 32'(a_in_ready), 32'd0);
                end
                a_out_ready = 1'b1;
            end
        join
        checkOutput("bp_third_held", 32'(waited3 >= 3), 32'd1);
        spins = 0;
        while ((qa.size() != 0 || a_out_valid) && spins < 100) begin
            @(posedge clk); #1;
            spins++;
        end
        checkOutput("bp_drained", 32'(a_out_valid), 32'd0);
        checkOutput("bp_op_count", 32'(a_op_count), 32'd11);

        $display("[TB] simultaneous push/pop");
        applyStimulus(24'($urandom), 3'($urandom), waited);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(24'($urandom), 3'($urandom), waited);
            checkOutput("pp_no_stall", 32'(waited), 32'd0);
            checkOutput("pp_out_valid", 32'(a_out_valid), 32'd1);
            checkOutput("pp_in_ready", 32'(a_in_ready), 32'd1);
        end
        @(posedge clk); #1;
        checkOutput("pp_op_count", 32'(a_op_count), 32'd22);

        $display("[TB] reset with two queued");
        a_out_ready = 1'b0;
        applyStimulus(24'($urandom), 3'($urandom), waited);
        applyStimulus(24'($urandom), 3'($urandom), waited);
        checkOutput("rst_pre_full", 32'(a_in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(a_out_data), 32'd0);
        checkOutput("rst_op_count", 32'(a_op_count), 32'd0);
        checkOutput("rst_in_ready", 32'(a_in_ready), 32'd0);
        checkOutput("rst_b_op_count", 32'(b_op_count), 32'd0);
        qa.delete();
        xfer_a = 0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_release_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("rst_release_out_valid", 32'(a_out_valid), 32'd0);
        a_out_ready = 1'b1;

        $display("[TB] random sweep");
        fork
            begin
                logic pushed;
                pushed = 1'b0;
                repeat (400) begin
                    if (!a_in_valid || pushed) begin
                        a_in_valid = ($urandom_range(0, 3) != 0);
                        a_in_data  = 24'($urandom);
                        a_op       = 3'($urandom);
                    end
                    a_out_ready = ($urandom_range(0, 3) != 0);
                    pushed = a_in_valid && a_in_ready;
                    if (pushed) qa.push_back(exp_t'{op: a_op, data: ref_model({104'b0, a_in_data}, 3, 8, a_op)});
                    @(posedge clk); #1;
                end
                a_in_valid = 1'b0;
            end
            begin
                logic pushed;
                pushed = 1'b0;
                repeat (400) begin
                    if (!c_in_valid || pushed) begin
                        c_in_valid = ($urandom_range(0, 2) != 0);
                        c_in_data  = 2'($urandom);
                        c_op       = 3'($urandom);
                    end
                    c_out_ready = ($urandom_range(0, 2) != 0);
                    pushed = c_in_valid && c_in_ready;
                    if (pushed) qc.push_back(exp_t'{op: c_op, data: ref_model({126'b0, c_in_data}, 2, 1, c_op)});
                    @(posedge clk); #1;
                end
                c_in_valid = 1'b0;
            end
            begin
                logic pushed;
                pushed = 1'b0;
                repeat (400) begin
                    if (!d_in_valid || pushed) begin
                        d_in_valid = ($urandom_range(0, 3) != 0);
                        d_in_data  = {$urandom, $urandom, $urandom, $urandom};
                        d_op       = 3'($urandom);
                    end
                    d_out_ready = ($urandom_range(0, 3) != 0);
                    pushed = d_in_valid && d_in_ready;
                    if (pushed) qd.push_back(exp_t'{op: d_op, data: ref_model(d_in_data, 8, 16, d_op)});
                    @(posedge clk); #1;
                end
                d_in_valid = 1'b0;
            end
        join

        a_out_ready = 1'b1;
        c_out_ready = 1'b1;
        d_out_ready = 1'b1;
        spins = 0;
        while ((qa.size() != 0 || qc.size() != 0 || qd.size() != 0 ||
                a_out_valid || c_out_valid || d_out_valid) && spins < 100) begin
            @(posedge clk); #1;
            spins++;
        end
        checkOutput("end_a_queue_empty", 32'(qa.size()), 32'd0);
        checkOutput("end_c_queue_empty", 32'(qc.size()), 32'd0);
        checkOutput("end_d_queue_empty", 32'(qd.size()), 32'd0);
        checkOutput("end_a_count", 32'(a_op_count), 32'(xfer_a));
        checkOutput("end_c_count", 32'(c_op_count), 32'(xfer_c));
        checkOutput("end_d_count", 32'(d_op_count), 32'(xfer_d));
        checkOutput("end_b_saturated", 32'(b_op_count), 32'(xfer_a > 7 ? 7 : xfer_a));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
